// File: rtl/row_skew_feeder_if.sv
// row_skew_feeder_if: groups the upstream vector handshake and the skewed
// row-feed outputs of row_skew_feeder.
//   in_valid/in_ready/in_data/in_last : upstream vector stream (one vector per accept)
//   out_en/out_a                      : per-lane enable and operand to the PU row
//   busy/done                         : status, done pulses once per completed tile
// Modports: slave = the feeder, master = whoever drives vectors and consumes lanes.
interface row_skew_feeder_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_last;
    logic [LANES-1:0]            out_en;
    logic [LANES*DATA_WIDTH-1:0] out_a;
    logic                        busy;
    logic                        done;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_en, out_a, busy, done
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_en, out_a, busy, done
    );
endinterface

// File: rtl/row_skew_feeder.sv
// row_skew_feeder: buffers operand vectors in a small FIFO and feeds them to a
// processing-unit row with a diagonal skew (lane i delayed by i clocks).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : row_skew_feeder_if.slave (in_valid/in_ready/in_data/in_last in,
//           out_en/out_a/busy/done out)
// Build option: define ROW_SKEW_FEEDER_ZERO_PAD_EN to drive 0 on lanes whose
// out_en is low; otherwise such lanes hold their previous operand.
module row_skew_feeder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned DEPTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    row_skew_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned VW = LANES * DATA_WIDTH;
    localparam int unsigned CW = $clog2(LANES);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [CW-1:0] CntOne = 1;
    localparam logic [CW-1:0] CntLoad = CW'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    // FIFO storage: {last, data}; pointers carry an extra wrap bit.
    logic [VW:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, push, pop, pop_last;
    logic [VW-1:0] pop_data;

    // Valid/last travel alongside the popped vector until they reach the last lane.
    logic [LANES-2:0]      pipe_vld_q, pipe_last_q;
    logic [LANES-1:0]      lane_vld;
    logic [DATA_WIDTH-1:0] lane_src [LANES];

    logic [LANES-1:0] out_en_q;
    logic [VW-1:0]    out_a_q;
    logic             done_q;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Readiness ignores a same-cycle pop so the handshake never depends on the FSM.
    assign push     = bus.in_valid && !full;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]][VW-1:0];
    assign pop_last = mem_q[rd_ptr_q[AW-1:0]][VW];

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pop         = 1'b0;
        unique case (state_q)
            // A last-flagged vector popped from IDLE ends its tile at once.
            StIdle, StStream: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (pop_last) begin
                        state_d     = StFlush;
                        flush_cnt_d = CntLoad;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StFlush: begin
                if (flush_cnt_q == CntOne) begin
                    state_d     = StIdle;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            pipe_vld_q[0]  <= pop;
            pipe_last_q[0] <= pop && pop_last;
            for (int unsigned k = 1; k < LANES - 1; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_last_q[k] <= pipe_last_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_last, bus.in_data};
    end

    assign lane_vld    = {pipe_vld_q, pop};
    assign lane_src[0] = pop_data[DATA_WIDTH-1:0];

    // Lane i keeps only its own element, delayed through an i-deep chain.
    for (genvar i = 1; i < LANES; i++) begin : g_skew
        logic [DATA_WIDTH-1:0] sk_q [i];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned j = 0; j < i; j++) sk_q[j] <= '0;
            end else begin
                sk_q[0] <= pop_data[i*DATA_WIDTH +: DATA_WIDTH];
                for (int unsigned j = 1; j < i; j++) sk_q[j] <= sk_q[j-1];
            end
        end
        assign lane_src[i] = sk_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_en_q <= '0;
            out_a_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            out_en_q <= lane_vld;
            done_q   <= pipe_vld_q[LANES-2] && pipe_last_q[LANES-2];
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_vld[i]) begin
                    out_a_q[i*DATA_WIDTH +: DATA_WIDTH] <= lane_src[i];
                end
`ifdef ROW_SKEW_FEEDER_ZERO_PAD_EN
                else begin
                    out_a_q[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
`else
                // Bubble lanes keep their last operand.
`endif
            end
        end
    end

    assign bus.in_ready = !full;
    assign bus.out_en   = out_en_q;
    assign bus.out_a    = out_a_q;
    assign bus.done     = done_q;
    assign bus.busy     = !empty || (state_q != StIdle);
endmodule

// File: tb/tb_row_skew_feeder.sv
module tb_row_skew_feeder;
    localparam int unsigned DW = 16;
    localparam int unsigned LN = 4;
    localparam int unsigned DP = 4;
    localparam int unsigned VW = DW * LN;

    logic clk = 1'b0;
    logic reset;

    row_skew_feeder_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

    row_skew_feeder #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: queue of accepted vectors, per-edge history of what
    // entered lane 0, and the edge index of the most recent last-flagged pop.
    typedef struct {
        logic          vld;
        logic [VW-1:0] data;
        logic          last;
    } vec_t;

    vec_t          fifo_m[$];
    vec_t          hist[$];   // hist[k] = vector popped k edges before the latest
    logic [DW-1:0] hold [LN];
    int            edge_n;
    int            lp;
    bit            in_tile;

    typedef struct {
        bit            v;
        logic [VW-1:0] d;
        bit            l;
        logic [LN-1:0] en;
        bit            dn;
        bit            bz;
        int            lane;
        logic [DW-1:0] val;
    } step_t;

    step_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        hist.delete();
        for (int i = 0; i < LN; i++) hold[i] = '0;
        edge_n  = 0;
        lp      = -100;
        in_tile = 1'b0;
    endtask

    task automatic compare_outputs();
        bit            ev;
        bit            edn;
        logic [DW-1:0] ea;
        for (int i = 0; i < LN; i++) begin
            ev = (i < hist.size()) && hist[i].vld;
            if (ev) hold[i] = hist[i].data[i*DW +: DW];
`ifdef ROW_SKEW_FEEDER_ZERO_PAD_EN
            ea = ev ? hold[i] : '0;
`else
            ea = hold[i];
`endif
            chk($sformatf("out_en[%0d]@%0d", i, edge_n), 64'(bus.out_en[i]), 64'(ev));
            chk($sformatf("out_a[%0d]@%0d", i, edge_n), 64'(bus.out_a[i*DW +: DW]), 64'(ea));
        end
        edn = (hist.size() >= LN) && hist[LN-1].vld && hist[LN-1].last;
        chk($sformatf("done@%0d", edge_n), 64'(bus.done), 64'(edn));
        if (bus.done) done_seen++;
        chk($sformatf("busy@%0d", edge_n), 64'(bus.busy),
            64'(fifo_m.size() > 0 || in_tile || (edge_n < lp + int'(LN) - 1)));
    endtask

    // Called #1 after a rising edge; drives inputs, checks in_ready, takes one
    // edge and checks every output against the model.
    task automatic cycle(input bit v, input logic [VW-1:0] d, input bit l, output bit acc);
        bit   rdy;
        bit   can_pop;
        vec_t popped;
        vec_t nv;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        rdy = fifo_m.size() < DP;
        #1;
        chk($sformatf("in_ready@%0d", edge_n), 64'(bus.in_ready), 64'(rdy));
        acc     = v && rdy;
        can_pop = (fifo_m.size() > 0) && (edge_n >= lp + int'(LN));
        @(posedge clk);
        #1;
        popped.vld  = 1'b0;
        popped.data = '0;
        popped.last = 1'b0;
        if (can_pop) begin
            popped = fifo_m.pop_front();
            if (popped.last) begin
                lp      = edge_n;
                in_tile = 1'b0;
            end else begin
                in_tile = 1'b1;
            end
        end
        if (acc) begin
            nv.vld  = 1'b1;
            nv.data = d;
            nv.last = l;
            fifo_m.push_back(nv);
        end
        hist.push_front(popped);
        if (hist.size() > LN) void'(hist.pop_back());
        compare_outputs();
        edge_n++;
    endtask

    task automatic send(input logic [VW-1:0] d, input bit l);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) cycle(1'b1, d, l, acc);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got not accepted, required accepted within 40 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int t = 0; t < n; t++) cycle(1'b0, '0, 1'b0, acc);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_out_en"}, 64'(bus.out_en), 64'(0));
        chk({tag, "_out_a"}, 64'(bus.out_a), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic run_table(input string tag);
        bit acc;
        for (int k = 0; k < 6; k++) begin
            cycle(tbl[k].v, tbl[k].d, tbl[k].l, acc);
            chk($sformatf("%s_en[%0d]", tag, k), 64'(bus.out_en), 64'(tbl[k].en));
            chk($sformatf("%s_done[%0d]", tag, k), 64'(bus.done), 64'(tbl[k].dn));
            chk($sformatf("%s_busy[%0d]", tag, k), 64'(bus.busy), 64'(tbl[k].bz));
            if (tbl[k].lane >= 0) begin
                chk($sformatf("%s_val[%0d]", tag, k),
                    64'(bus.out_a[tbl[k].lane*DW +: DW]), 64'(tbl[k].val));
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] va;
        logic [VW-1:0] vb;
        int            d0;
        bit            acc;

        tbl[0] = '{1'b1, 64'h0004_0003_0002_0001, 1'b1, 4'b0000, 1'b0, 1'b1, -1, 16'h0000};
        tbl[1] = '{1'b0, 64'h0, 1'b0, 4'b0001, 1'b0, 1'b1, 0, 16'h0001};
        tbl[2] = '{1'b0, 64'h0, 1'b0, 4'b0010, 1'b0, 1'b1, 1, 16'h0002};
        tbl[3] = '{1'b0, 64'h0, 1'b0, 4'b0100, 1'b0, 1'b1, 2, 16'h0003};
        tbl[4] = '{1'b0, 64'h0, 1'b0, 4'b1000, 1'b1, 1'b0, 3, 16'h0004};
        tbl[5] = '{1'b0, 64'h0, 1'b0, 4'b0000, 1'b0, 1'b0, -1, 16'h0000};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        reset        = 1'b1;
        #1;
        reset_check("por");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Single last-flagged vector through an idle feeder.
        run_table("single");

        // Five vectors queued behind a tile in FLUSH: FIFO fills, fifth waits.
        send(64'h00AA_00AA_00AA_00AA, 1'b1);
        send(64'h0114_0113_0112_0111, 1'b0);
        send(64'h0124_0123_0122_0121, 1'b0);
        send(64'h0134_0133_0132_0131, 1'b0);
        send(64'h0144_0143_0142_0141, 1'b0);
        chk("full_in_ready", 64'(bus.in_ready), 64'(0));
        send(64'h0154_0153_0152_0151, 1'b1);
        idle(12);

        // A, gap, B(last): one bubble per lane, staggered by lane index.
        va = 64'hA004_A003_A002_A001;
        vb = 64'hB004_B003_B002_B001;
        send(va, 1'b0);
        idle(1);
        send(vb, 1'b1);
`ifdef ROW_SKEW_FEEDER_ZERO_PAD_EN
        chk("bubble_lane0_a", 64'(bus.out_a[DW-1:0]), 64'(0));
`else
        chk("bubble_lane0_a", 64'(bus.out_a[DW-1:0]), 64'(va[DW-1:0]));
`endif
        chk("bubble_lane0_en", 64'(bus.out_en[0]), 64'(0));
        idle(1);
`ifdef ROW_SKEW_FEEDER_ZERO_PAD_EN
        chk("bubble_lane1_a", 64'(bus.out_a[2*DW-1:DW]), 64'(0));
`else
        chk("bubble_lane1_a", 64'(bus.out_a[2*DW-1:DW]), 64'(va[2*DW-1:DW]));
`endif
        idle(10);

        // Two tiles back-to-back: last on vectors 2 and 4.
        d0 = done_seen;
        send(64'h0C04_0C03_0C02_0C01, 1'b0);
        send(64'h0C14_0C13_0C12_0C11, 1'b1);
        send(64'h0D04_0D03_0D02_0D01, 1'b0);
        send(64'h0D14_0D13_0D12_0D11, 1'b1);
        idle(14);
        chk("two_tiles_done_count", 64'(done_seen - d0), 64'(2));

        // Reset while the flush counter sits at 2.
        send(64'h0E04_0E03_0E02_0E01, 1'b0);
        send(64'h0E14_0E13_0E12_0E11, 1'b1);
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        reset_check("mid_flush");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            reset_check($sformatf("held%0d", k));
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        d0 = done_seen;
        idle(4);
        chk("no_done_after_abort", 64'(done_seen - d0), 64'(0));
        run_table("restart");

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), acc);
        end
        bus.in_valid = 1'b0;
        send(64'h0F04_0F03_0F02_0F01, 1'b1);
        idle(20);
        chk("drain_busy", 64'(bus.busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/row_skew_feeder.md
ROW_SKEW_FEEDER -- requirements
Module: row_skew_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, operand width per lane.
REQ-002 The block SHALL have parameter LANES, default 4, lanes (array rows) fed, legal range 2..16.
REQ-003 The block SHALL have parameter DEPTH, default 8, input FIFO depth in vectors, power of two, at least 2.
REQ-004 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  upstream vector valid.
REQ-007 in_ready  out  1  FIFO can accept a vector.
REQ-008 in_data  in  LANES*DATA_WIDTH  operand vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_last  in  1  marks the final vector of a tile.
REQ-010 out_en  out  LANES  per-lane enable to the processing-unit row.
REQ-011 out_a  out  LANES*DATA_WIDTH  skewed per-lane operands, same packing as in_data.
REQ-012 busy  out  1  high while FIFO non-empty or state not IDLE.
REQ-013 done  out  1  one-cycle pulse at tile completion.

Function
REQ-014 The block SHALL accept a vector (data plus in_last) on any edge where in_valid and in_ready are both high.
REQ-015 in_ready SHALL equal FIFO-not-full only, independent of a same-cycle pop; no push at full even when popping.
REQ-016 FSM states SHALL be IDLE, STREAM, FLUSH.
REQ-017 IDLE: on an edge with FIFO non-empty, pop one vector, go to STREAM.
REQ-018 STREAM: pop one vector per edge while FIFO non-empty; on an empty FIFO, insert a bubble (no pop, lane 0 carries no valid data).
REQ-019 STREAM: popping a vector with in_last set SHALL move to FLUSH on the same edge.
REQ-020 FLUSH: no pops for LANES-1 edges (down-counter), then return to IDLE; pushes still accepted.
REQ-021 A vector popped on edge P SHALL present element i on out_a lane i, with out_en[i]=1, during the cycle after edge P+i (lane i delayed i clocks).
REQ-022 out_en[i] SHALL be 0 whenever lane i carries a bubble or no data.
REQ-023 done SHALL be high exactly in the cycle where out_en[LANES-1] presents the last-flagged vector.
REQ-024 Vectors SHALL leave in FIFO order with no loss or duplication; pointers wrap modulo DEPTH.
REQ-025 Minimum latency: vector accepted on edge E into empty FIFO in IDLE appears on lane 0 after edge E+1.

Reset
REQ-026 Reset assertion SHALL immediately force: FIFO empty, FSM IDLE, flush counter 0, all skew registers, out_en, out_a, done to 0; busy 0; in_ready 1.
REQ-027 Reset mid-tile SHALL discard all buffered and in-flight vectors; no done pulse for the aborted tile.
REQ-028 First pop after reset release SHALL occur no earlier than the edge after the first accept.

Configuration
REQ-029 Macro ROW_SKEW_FEEDER_ZERO_PAD_EN SHALL select bubble data handling.
REQ-030 Defined: every lane with out_en[i]=0 SHALL drive out_a lane i = 0.
REQ-031 Undefined: lane with out_en[i]=0 SHALL hold its previous out_a value; enables and timing identical in both builds.

Verification (LANES=4, DATA_WIDTH=16, DEPTH=4)
REQ-032 Single vector {lane3..0}=0x0004,0x0003,0x0002,0x0001, in_last=1 -> lane 0=0x0001 cycle after E+1, lane 3=0x0004 cycle after E+4, done with it, then IDLE, busy 0.
REQ-033 Push 5 vectors back-to-back with no pops possible (held by preceding tile in FLUSH) -> in_ready low after 4th accept, 5th held, accepted when a slot frees; order preserved.
REQ-034 Vector A, one idle cycle, vector B (last) -> one-cycle bubble on each lane, offset by lane index; out_en pattern 1,0,1 per lane.
REQ-035 Two tiles back-to-back, last on vectors 2 and 4 -> no pops for 3 edges after vector 2 pop, exactly two done pulses.
REQ-036 Reset asserted while FLUSH counter =2 -> outputs zero asynchronously, no done, restart with new tile behaves as REQ-032.
REQ-037 Bubble check both builds -> out_a lane=0 with macro defined, previous value held without it.
